// File: rtl/dmem_if.sv
// Request/response bus between the pipeline MEM stage (master) and the
// data-memory responder (slave). One outstanding request at a time.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// performs the access, then holds the response until the consumer takes it.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- flags misaligned word
// accesses (no write, rdata 0, err 1). Without it word accesses ignore
// addr[1:0] and rsp_err is always 0.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             we_q, byte_q, uns_q;
  logic [11:0]      addr_q;
  logic [31:0]      wdata_q;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             access;
  logic             misalign;
  logic             mem_we;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_rd;
  logic [31:0]      load_val;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
    return uns ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign idx      = IDX_W'(32'(addr_q[11:2]) % 32'(DEPTH_WORDS));
  assign word_rd  = mem[idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = !byte_q && (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_we   = access && we_q && !misalign;
  assign load_val = byte_q ? extend_byte(lane_byte(word_rd, addr_q[1:0]), uns_q) : word_rd;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state, wait counter and response capture on the BUSY->RESP edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || misalign) ? 32'h0 : load_val;
          err_d   = misalign;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields latched at acceptance; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      byte_q  <= bus.req_byte;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= byte_q ? merge_byte(word_rd, addr_q[1:0], wdata_q[7:0]) : wdata_q;
    end
  end
endmodule
